enm_bullet: RTL and testbench
=============================

// Module: enm_bullet
// PURPOSE
//  Enemy-side projectile engine: counterpart to the player-bullet/hit logic. Fires bullets downward from
//  live enemies and the boss, moves them one pixel per clk_1ms tick, detects hits on the player plane
//  and keeps the player HP. Feeds bullet coordinates to the VGA renderer and planehp/dead to game control.
// PARAMETERS
//  FIRE_PERIOD  400  ticks between fire events (counter terminal count = FIRE_PERIOD-1)
//  BOTTOM       479  bullet freed when eby >= BOTTOM
//  HIT_DX       20   hit when |ebx-planex| < HIT_DX
//  HIT_DY       20   hit when |eby-planey| < HIT_DY
//  DMG          10   player HP lost per hit
//  PLANE_HP     100  player HP after reset
// PORTS
//  clk_1ms          in   1   game tick clock; all logic on posedge
//  switch           in   1   synchronous active-high reset / game restart
//  planex, planey   in   10  player plane centre
//  bossx, bossy     in   10  boss centre
//  enmx1..4,enmy1..4 in  10  enemy centres
//  enmhp1..4        in   7   enemy HP; source may fire only if HP > 0
//  bosshp           in   10  boss HP; boss may fire only if HP > 0
//  ebx1..4, eby1..4 out  10  bullet slot coordinates (registered)
//  ebv              out  4   ebv[i]=1: slot i+1 in flight
//  planehp          out  7   player HP, saturates at 0
//  dead             out  1   registered, 1 when planehp == 0
// BEHAVIOUR
//  Reset (switch=1 at edge): ebv=0, ebx*/eby*=0, planehp=PLANE_HP, dead=0, fire counter=0, source ptr=0.
//   Takes priority over all other activity; mid-flight bullets are discarded.
//  Slot states per bullet: IDLE (ebv=0) -> FLY (ebv=1) -> IDLE. Four slots, fixed.
//  Fire counter: increments every tick, wraps at FIRE_PERIOD-1; wrap tick = fire event.
//  Fire event: source ptr selects 0..3 = enemy1..4, 4 = boss; ptr advances (4->0) on every event.
//   If source HP>0, dead=0 and an IDLE slot exists: lowest-index IDLE slot -> FLY,
//   ebx=srcx, eby=srcy+18 (enemy) or srcy+24 (boss). Otherwise the shot is dropped silently.
//  FLY slot, each tick, priority order:
//   1. hit: (ebx+HIT_DX>planex)&&(planex+HIT_DX>ebx)&&(eby+HIT_DY>planey)&&(planey+HIT_DY>eby)
//      (11-bit compares, no wrap) -> slot IDLE, coords zeroed, damage DMG.
//   2. eby >= BOTTOM -> slot IDLE, coords zeroed, no damage.
//   3. else eby <= eby+1; ebx unchanged.
//  Slot loaded on a fire event is not checked/moved until the next tick.
//  Slot freed at tick t is eligible for a fire event at t+1, not t.
//  Simultaneous hits: total = DMG * hit count, applied in one update; planehp saturates at 0.
//  dead: set the tick after planehp reaches 0; while dead no new shots, bullets keep flying,
//   hits still free slots, planehp stays 0. Cleared only by switch.
//  Latency: fire event -> ebv visible 1 tick; hit -> planehp update same edge as slot freed.
// TESTING
//  T1 reset: switch=1 one edge mid-flight -> ebv=0000, planehp=100, dead=0, counter restarts.
//  T2 fire/fly (FIRE_PERIOD=4): enemy1 (200,100) alive, plane (500,400) -> tick 4 ebv=0001,
//     (200,118); eby +1/tick; freed on tick eby=479, no HP change.
//  T3 hit: plane (200,150), bullet from (200,100) -> freed when eby=131, planehp 100->90.
//  T4 dead source: enmhp1=0 -> first event spawns nothing, ptr moves; second event spawns from enemy2.
//  T5 pool full: 4 slots FLY, fire event with live source -> dropped, ebv stays 1111, ptr advances.
//  T6 saturation: planehp=15, two bullets hit same tick -> planehp=0, dead=1 next tick, no spawns.

Source files
------------

// File: rtl/enm_bullet.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : enm_bullet                                                    |
// | Purpose  : Enemy/boss projectile pool with fire scheduler, flight, hit   |
// |            detection against the player plane and player HP tracking.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module enm_bullet #(
    parameter int FIRE_PERIOD = 400,
    parameter int BOTTOM      = 479,
    parameter int HIT_DX      = 20,
    parameter int HIT_DY      = 20,
    parameter int DMG         = 10,
    parameter int PLANE_HP    = 100
) (
    input  logic       clk_1ms,
    input  logic       switch,
    input  logic [9:0] planex,
    input  logic [9:0] planey,
    input  logic [9:0] bossx,
    input  logic [9:0] bossy,
    input  logic [9:0] enmx1,
    input  logic [9:0] enmx2,
    input  logic [9:0] enmx3,
    input  logic [9:0] enmx4,
    input  logic [9:0] enmy1,
    input  logic [9:0] enmy2,
    input  logic [9:0] enmy3,
    input  logic [9:0] enmy4,
    input  logic [6:0] enmhp1,
    input  logic [6:0] enmhp2,
    input  logic [6:0] enmhp3,
    input  logic [6:0] enmhp4,
    input  logic [9:0] bosshp,
    output logic [9:0] ebx1,
    output logic [9:0] ebx2,
    output logic [9:0] ebx3,
    output logic [9:0] ebx4,
    output logic [9:0] eby1,
    output logic [9:0] eby2,
    output logic [9:0] eby3,
    output logic [9:0] eby4,
    output logic [3:0] ebv,
    output logic [6:0] planehp,
    output logic       dead
);

    localparam int               CNT_W    = (FIRE_PERIOD > 1) ? $clog2(FIRE_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FIRE_PERIOD - 1);
    localparam logic [9:0]       ENM_OFS  = 10'd18;
    localparam logic [9:0]       BOSS_OFS = 10'd24;
    localparam logic [9:0]       BOT_V    = 10'(BOTTOM);
    localparam logic [10:0]      DX_V     = 11'(HIT_DX);
    localparam logic [10:0]      DY_V     = 11'(HIT_DY);
    localparam logic [9:0]       DMG_V    = 10'(DMG);
    localparam logic [6:0]       HP_INIT  = 7'(PLANE_HP);

    typedef enum logic [0:0] {
        SLOT_IDLE = 1'b0,
        SLOT_FLY  = 1'b1
    } slot_state_e;

    slot_state_e      st_q [4];
    slot_state_e      st_d [4];
    logic [9:0]       bx_q [4];
    logic [9:0]       bx_d [4];
    logic [9:0]       by_q [4];
    logic [9:0]       by_d [4];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [6:0]       hp_q, hp_d;
    logic             dead_q, dead_d;

    logic [9:0] w_enmx  [4];
    logic [9:0] w_enmy  [4];
    logic [6:0] w_enmhp [4];

    logic       w_fire;
    logic       w_src_live;
    logic [9:0] w_src_x;
    logic [9:0] w_src_y;
    logic [3:0] w_hit;
    logic [3:0] w_bot;
    logic [2:0] w_hit_cnt;
    logic [9:0] w_dmg;
    logic [9:0] w_hp_ext;
    logic       w_free_ok;
    logic [1:0] w_free_idx;

    assign w_enmx  = '{enmx1, enmx2, enmx3, enmx4};
    assign w_enmy  = '{enmy1, enmy2, enmy3, enmy4};
    assign w_enmhp = '{enmhp1, enmhp2, enmhp3, enmhp4};

    assign w_fire = (cnt_q == CNT_LAST);

    // Source pointer 0..3 selects enemy1..4, 4 selects the boss.
    always_comb begin
        w_src_live = 1'b0;
        w_src_x    = '0;
        w_src_y    = '0;
        case (ptr_q)
            3'd0, 3'd1, 3'd2, 3'd3: begin
                w_src_live = (w_enmhp[ptr_q[1:0]] != '0);
                w_src_x    = w_enmx[ptr_q[1:0]];
                w_src_y    = w_enmy[ptr_q[1:0]] + ENM_OFS;
            end
            3'd4: begin
                w_src_live = (bosshp != '0);
                w_src_x    = bossx;
                w_src_y    = bossy + BOSS_OFS;
            end
            default: ;
        endcase
    end

    // Widened compares keep the box test free of 10-bit wrap-around.
    for (genvar i = 0; i < 4; i++) begin : g_slot
        assign w_hit[i] = (st_q[i] == SLOT_FLY)
                       && ({1'b0, bx_q[i]} + DX_V > {1'b0, planex})
                       && ({1'b0, planex} + DX_V > {1'b0, bx_q[i]})
                       && ({1'b0, by_q[i]} + DY_V > {1'b0, planey})
                       && ({1'b0, planey} + DY_V > {1'b0, by_q[i]});
        assign w_bot[i] = (st_q[i] == SLOT_FLY) && !w_hit[i] && (by_q[i] >= BOT_V);
    end

    always_comb begin
        w_hit_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            w_hit_cnt = w_hit_cnt + {2'b00, w_hit[i]};
        end
    end

    assign w_dmg    = 10'(w_hit_cnt) * DMG_V;
    assign w_hp_ext = {3'b000, hp_q};

    // Only slots idle before this tick are eligible, so a slot freed now waits a tick.
    always_comb begin
        w_free_ok  = 1'b0;
        w_free_idx = '0;
        for (int i = 3; i >= 0; i--) begin
            if (st_q[i] == SLOT_IDLE) begin
                w_free_ok  = 1'b1;
                w_free_idx = 2'(i);
            end
        end
    end

    always_comb begin
        cnt_d  = w_fire ? '0 : cnt_q + 1'b1;
        ptr_d  = ptr_q;
        hp_d   = (w_hp_ext > w_dmg) ? (hp_q - w_dmg[6:0]) : '0;
        dead_d = dead_q | (hp_q == '0);
        for (int i = 0; i < 4; i++) begin
            st_d[i] = st_q[i];
            bx_d[i] = bx_q[i];
            by_d[i] = by_q[i];
            if (w_hit[i] || w_bot[i]) begin
                st_d[i] = SLOT_IDLE;
                bx_d[i] = '0;
                by_d[i] = '0;
            end else if (st_q[i] == SLOT_FLY) begin
                by_d[i] = by_q[i] + 10'd1;
            end
        end
        if (w_fire) begin
            ptr_d = (ptr_q == 3'd4) ? 3'd0 : ptr_q + 3'd1;
            if (w_src_live && !dead_q && w_free_ok) begin
                st_d[w_free_idx] = SLOT_FLY;
                bx_d[w_free_idx] = w_src_x;
                by_d[w_free_idx] = w_src_y;
            end
        end
    end

    always_ff @(posedge clk_1ms) begin
        if (switch) begin
            for (int i = 0; i < 4; i++) begin
                st_q[i] <= SLOT_IDLE;
                bx_q[i] <= '0;
                by_q[i] <= '0;
            end
            cnt_q  <= '0;
            ptr_q  <= '0;
            hp_q   <= HP_INIT;
            dead_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                st_q[i] <= st_d[i];
                bx_q[i] <= bx_d[i];
                by_q[i] <= by_d[i];
            end
            cnt_q  <= cnt_d;
            ptr_q  <= ptr_d;
            hp_q   <= hp_d;
            dead_q <= dead_d;
        end
    end

    assign ebx1    = bx_q[0];
    assign ebx2    = bx_q[1];
    assign ebx3    = bx_q[2];
    assign ebx4    = bx_q[3];
    assign eby1    = by_q[0];
    assign eby2    = by_q[1];
    assign eby3    = by_q[2];
    assign eby4    = by_q[3];
    assign ebv     = {st_q[3] == SLOT_FLY, st_q[2] == SLOT_FLY,
                      st_q[1] == SLOT_FLY, st_q[0] == SLOT_FLY};
    assign planehp = hp_q;
    assign dead    = dead_q;

endmodule
`default_nettype wire

// File: tb/tb_enm_bullet.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_enm_bullet                                                 |
// | Purpose  : Scoreboard bench for enm_bullet with a behavioural model.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_enm_bullet;

    localparam int FP       = 4;
    localparam int BOTTOM   = 479;
    localparam int HIT_DX   = 20;
    localparam int HIT_DY   = 20;
    localparam int DMG      = 10;
    localparam int PLANE_HP = 100;

    logic       clk_1ms = 1'b0;
    logic       switch  = 1'b1;
    logic [9:0] planex  = '0;
    logic [9:0] planey  = '0;
    logic [9:0] bossx   = '0;
    logic [9:0] bossy   = '0;
    logic [9:0] bosshp  = '0;
    logic [9:0] enmx [4];
    logic [9:0] enmy [4];
    logic [6:0] enmhp [4];

    logic [9:0] ebx1, ebx2, ebx3, ebx4, eby1, eby2, eby3, eby4;
    logic [3:0] ebv;
    logic [6:0] planehp;
    logic       dead;

    always #5 clk_1ms = ~clk_1ms;

    enm_bullet #(
        .FIRE_PERIOD(FP), .BOTTOM(BOTTOM), .HIT_DX(HIT_DX), .HIT_DY(HIT_DY),
        .DMG(DMG), .PLANE_HP(PLANE_HP)
    ) dut (
        .clk_1ms(clk_1ms), .switch(switch),
        .planex(planex), .planey(planey), .bossx(bossx), .bossy(bossy),
        .enmx1(enmx[0]), .enmx2(enmx[1]), .enmx3(enmx[2]), .enmx4(enmx[3]),
        .enmy1(enmy[0]), .enmy2(enmy[1]), .enmy3(enmy[2]), .enmy4(enmy[3]),
        .enmhp1(enmhp[0]), .enmhp2(enmhp[1]), .enmhp3(enmhp[2]), .enmhp4(enmhp[3]),
        .bosshp(bosshp),
        .ebx1(ebx1), .ebx2(ebx2), .ebx3(ebx3), .ebx4(ebx4),
        .eby1(eby1), .eby2(eby2), .eby3(eby3), .eby4(eby4),
        .ebv(ebv), .planehp(planehp), .dead(dead)
    );

    typedef struct packed {
        logic [3:0]       v;
        logic [3:0][9:0]  x;
        logic [3:0][9:0]  y;
        logic [6:0]       hp;
        logic             d;
    } exp_t;

    exp_t sbq [$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Reference model: a list of bullets as plain integers.
    int mx [4];
    int my [4];
    bit mv [4];
    int mcnt, mptr, mhp;
    bit mdead;

    task automatic check(string name, int act, int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic model_step();
        bit   idle [4];
        int   hits, sx, sy, shp, adx, ady, slot;
        bit   fire, new_dead;
        exp_t e;
        if (switch) begin
            for (int i = 0; i < 4; i++) begin
                mv[i] = 0; mx[i] = 0; my[i] = 0;
            end
            mcnt = 0; mptr = 0; mhp = PLANE_HP; mdead = 0;
        end else begin
            hits = 0;
            for (int i = 0; i < 4; i++) idle[i] = !mv[i];
            fire = (mcnt == FP - 1);
            mcnt = fire ? 0 : mcnt + 1;
            for (int i = 0; i < 4; i++) begin
                if (mv[i]) begin
                    adx = mx[i] - int'(planex); if (adx < 0) adx = -adx;
                    ady = my[i] - int'(planey); if (ady < 0) ady = -ady;
                    if (adx < HIT_DX && ady < HIT_DY) begin
                        hits++; mv[i] = 0; mx[i] = 0; my[i] = 0;
                    end else if (my[i] >= BOTTOM) begin
                        mv[i] = 0; mx[i] = 0; my[i] = 0;
                    end else begin
                        my[i] = my[i] + 1;
                    end
                end
            end
            if (fire) begin
                if (mptr == 4) begin
                    sx = bossx; sy = (int'(bossy) + 24) % 1024; shp = bosshp;
                end else begin
                    sx = enmx[mptr]; sy = (int'(enmy[mptr]) + 18) % 1024; shp = enmhp[mptr];
                end
                slot = -1;
                for (int i = 3; i >= 0; i--) if (idle[i]) slot = i;
                if (shp > 0 && !mdead && slot >= 0) begin
                    mv[slot] = 1; mx[slot] = sx; my[slot] = sy;
                end
                mptr = (mptr + 1) % 5;
            end
            new_dead = mdead || (mhp == 0);
            mhp = mhp - DMG * hits;
            if (mhp < 0) mhp = 0;
            mdead = new_dead;
        end
        for (int i = 0; i < 4; i++) begin
            e.v[i] = mv[i];
            e.x[i] = 10'(mx[i]);
            e.y[i] = 10'(my[i]);
        end
        e.hp = 7'(mhp);
        e.d  = mdead;
        sbq.push_back(e);
    endtask

    // Monitor: every tick the DUT presents a full state, compared against the queue head.
    always @(negedge clk_1ms) begin
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            check("ebv", int'(ebv), int'(mon_e.v));
            check("ebx1", int'(ebx1), int'(mon_e.x[0]));
            check("ebx2", int'(ebx2), int'(mon_e.x[1]));
            check("ebx3", int'(ebx3), int'(mon_e.x[2]));
            check("ebx4", int'(ebx4), int'(mon_e.x[3]));
            check("eby1", int'(eby1), int'(mon_e.y[0]));
            check("eby2", int'(eby2), int'(mon_e.y[1]));
            check("eby3", int'(eby3), int'(mon_e.y[2]));
            check("eby4", int'(eby4), int'(mon_e.y[3]));
            check("planehp", int'(planehp), int'(mon_e.hp));
            check("dead", int'(dead), int'(mon_e.d));
        end
    end

    task automatic tick();
        model_step();
        @(posedge clk_1ms);
        @(negedge clk_1ms);
        #1;
    endtask

    task automatic do_reset();
        switch = 1'b1;
        tick();
        switch = 1'b0;
    endtask

    task automatic all_dead();
        for (int i = 0; i < 4; i++) begin
            enmhp[i] = '0; enmx[i] = 10'd100; enmy[i] = 10'd50;
        end
        bosshp = '0; bossx = 10'd400; bossy = 10'd30;
    endtask

    task automatic scramble();
        for (int i = 0; i < 4; i++) begin
            enmx[i]  = 10'($urandom_range(150, 350));
            enmy[i]  = ($urandom_range(0, 15) == 0) ? 10'($urandom_range(1000, 1023))
                                                    : 10'($urandom_range(20, 200));
            enmhp[i] = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
        end
        bossx  = 10'($urandom_range(150, 350));
        bossy  = 10'($urandom_range(10, 100));
        bosshp = ($urandom_range(0, 2) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
        planex = 10'($urandom_range(140, 360));
        planey = 10'($urandom_range(230, 470));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        all_dead();
        switch = 1'b1;
        tick();
        tick();
        check("rst_ebv", int'(ebv), 0);
        check("rst_hp", int'(planehp), PLANE_HP);
        check("rst_dead", int'(dead), 0);

        // Single enemy, plane out of the way: spawn, fly to the bottom.
        enmhp[0] = 7'd50; enmx[0] = 10'd200; enmy[0] = 10'd100;
        planex = 10'd500; planey = 10'd400;
        switch = 1'b0;
        repeat (3) tick();
        check("fly_pre_ebv", int'(ebv), 0);
        tick();
        check("fly_ebv", int'(ebv[0]), 1);
        check("fly_x", int'(ebx1), 200);
        check("fly_y", int'(eby1), 118);
        repeat (10) tick();
        check("fly_y10", int'(eby1), 128);
        repeat (351) tick();
        check("bot_y", int'(eby1), 479);
        check("bot_v", int'(ebv[0]), 1);
        tick();
        check("bot_free", int'(ebv[0]), 0);
        check("bot_hp", int'(planehp), 100);

        // Mid-flight restart.
        do_reset();
        check("t1_ebv", int'(ebv), 0);
        check("t1_hp", int'(planehp), 100);
        check("t1_dead", int'(dead), 0);
        repeat (3) tick();
        check("t1_cnt_pre", int'(ebv), 0);
        tick();
        check("t1_cnt_fire", int'(ebv), 1);

        // Hit on the plane.
        do_reset();
        planex = 10'd200; planey = 10'd150;
        repeat (17) tick();
        check("hit_pre_y", int'(eby1), 131);
        check("hit_pre_hp", int'(planehp), 100);
        tick();
        check("hit_ebv", int'(ebv), 0);
        check("hit_hp", int'(planehp), 90);

        // Dead source is skipped, pointer still moves on.
        do_reset();
        planex = 10'd500; planey = 10'd400;
        enmhp[0] = 7'd0; enmhp[1] = 7'd30; enmx[1] = 10'd300; enmy[1] = 10'd50;
        repeat (4) tick();
        check("src_dead_ebv", int'(ebv), 0);
        repeat (4) tick();
        check("src2_ebv", int'(ebv), 1);
        check("src2_x", int'(ebx1), 300);
        check("src2_y", int'(eby1), 68);

        // Pool full: further shots are dropped.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            enmhp[i] = 7'd60; enmx[i] = 10'(100 + 60 * i); enmy[i] = 10'd50;
        end
        bosshp = 10'd500; planex = 10'd900; planey = 10'd400;
        repeat (16) tick();
        check("full_ebv", int'(ebv), 15);
        repeat (8) tick();
        check("full_ebv2", int'(ebv), 15);

        // Aligned columns drain the plane to zero, then no more shots.
        do_reset();
        all_dead();
        for (int i = 0; i < 3; i++) begin
            enmhp[i] = 7'd40; enmx[i] = 10'd200; enmy[i] = 10'(100 + 4 * i);
        end
        planex = 10'd200; planey = 10'd200;
        repeat (400) tick();
        check("sat_hp", int'(planehp), 0);
        check("sat_dead", int'(dead), 1);
        check("sat_ebv", int'(ebv), 0);

        // Randomized play.
        do_reset();
        scramble();
        for (int n = 0; n < 5000; n++) begin
            if ($urandom_range(0, 39) == 0) scramble();
            switch = ($urandom_range(0, 599) == 0);
            tick();
        end
        switch = 1'b0;

        @(negedge clk_1ms);
        #1;
        check("sb_drain", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
